// File: rtl/dff_pipe_pkg.sv
// rtl/dff_pipe_pkg.sv - shared helpers for the dff_pipe register pipeline
package dff_pipe_pkg;

  localparam int PARITY_MAX_WIDTH = 64;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one data/valid slice of dff_pipe with load enable
// Optional parity storage: DFF_PIPE_PARITY_EN
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  input  logic             d_par,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid,
  output logic             q_par
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // A clear drops the entry but leaves the data register untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= d_data;
      valid_q <= d_valid;
    end
  end

  assign q_data  = data_q;
  assign q_valid = valid_q;

`ifdef DFF_PIPE_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= even_parity(PARITY_MAX_WIDTH'(RESET_VAL));
    end else if (!clear && load) begin
      par_q <= d_par;
    end
  end

  assign q_par = par_q;
`else
  logic unused_d_par;
  assign unused_d_par = d_par;
  assign q_par        = 1'b0;
`endif

endmodule

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - DEPTH-stage valid/ready register pipeline with bubble collapsing
// Optional per-stage parity and sticky par_err: DFF_PIPE_PARITY_EN
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           flush,
  output logic [count_width(DEPTH)-1:0]  count,
  output logic                           par_err
);

  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] data_q     [DEPTH];
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_par;
  logic [DEPTH-1:0] stage_free;
  logic             in_hs;
  logic             out_hs;

  // A stage is free when empty or when everything downstream of it can move.
  always_comb begin
    stage_free            = '0;
    stage_free[DEPTH-1]   = !valid_q[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      stage_free[i] = !valid_q[i] || stage_free[i+1];
    end
  end

  assign in_ready = stage_free[0];
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign stage_data[g]  = in_data;
        assign stage_valid[g] = in_hs;
        assign stage_par[g]   = even_parity(PARITY_MAX_WIDTH'(in_data));
      end else begin : g_body
        assign stage_data[g]  = data_q[g-1];
        assign stage_valid[g] = valid_q[g-1];
        assign stage_par[g]   = par_q[g-1];
      end

      dff_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (stage_free[g]),
        .d_data  (stage_data[g]),
        .d_valid (stage_valid[g]),
        .d_par   (stage_par[g]),
        .q_data  (data_q[g]),
        .q_valid (valid_q[g]),
        .q_par   (par_q[g])
      );
    end
  endgenerate

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      case ({in_hs, out_hs})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err <= 1'b0;
    end else if (out_valid && (par_q[DEPTH-1] != even_parity(PARITY_MAX_WIDTH'(out_data)))) begin
      par_err <= 1'b1;
    end
  end
`else
  logic unused_last_par;
  assign unused_last_par = par_q[DEPTH-1];
  assign par_err         = 1'b0;
`endif

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter: WIDTH, 8, data bits per stage.
REQ-002 Parameter: DEPTH, 4, number of register stages (legal range 1..16).
REQ-003 Parameter: RESET_VAL, '0, value loaded into every stage data register on reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  reset, synchronous, active-high.
REQ-006 Port: in_valid  input  1  upstream data valid.
REQ-007 Port: in_ready  output  1  pipe accepts in_data this cycle.
REQ-008 Port: in_data  input  WIDTH  upstream data.
REQ-009 Port: out_valid  output  1  last stage holds valid data.
REQ-010 Port: out_ready  input  1  downstream accepts out_data.
REQ-011 Port: out_data  output  WIDTH  last-stage data.
REQ-012 Port: flush  input  1  discard all in-flight entries.
REQ-013 Port: count  output  $clog2(DEPTH+1)  number of valid stages.
REQ-014 Port: par_err  output  1  sticky parity error flag.

Function
REQ-015 Stage i SHALL hold data_q[i] and valid_q[i]; stage 0 is input side, stage DEPTH-1 drives out_data/out_valid directly from registers.
REQ-016 Stage DEPTH-1 SHALL be free when !valid_q[DEPTH-1] or out_ready; stage i<DEPTH-1 SHALL be free when !valid_q[i] or stage i+1 is free (bubble collapsing).
REQ-017 in_ready SHALL equal "stage 0 free" and SHALL be combinational from out_ready and valid_q only, never from in_valid.
REQ-018 A free stage SHALL load its predecessor's data/valid (stage 0 loads in_data, in_valid && in_ready); a non-free stage SHALL hold.
REQ-019 Latency with out_ready=1 throughout SHALL be exactly DEPTH cycles from input handshake to out_valid; throughput SHALL be one item per cycle.
REQ-020 Entries SHALL leave in acceptance order; no item dropped or duplicated under any in_valid/out_ready pattern.
REQ-021 count SHALL be a register: +1 on input handshake only, -1 on output handshake only, unchanged on both or neither; range 0..DEPTH.
REQ-022 Full (count==DEPTH) with out_ready=0 SHALL give in_ready=0; full with out_ready=1 SHALL give in_ready=1 (simultaneous in/out).
REQ-023 flush SHALL clear all valid_q and count to 0 on the next edge, taking priority over any handshake that cycle; data_q SHALL be left unchanged.
REQ-024 During a flush cycle in_ready SHALL still be computed per REQ-017, but the accepted item SHALL be discarded.
REQ-025 DEPTH=1 SHALL behave as a single registered slice without combinational in-to-out path.

Reset
REQ-026 On reset: valid_q all 0, data_q all RESET_VAL, count=0, par_err=0, out_valid=0, out_data=RESET_VAL.
REQ-027 Reset SHALL override flush and handshakes; reset mid-transfer SHALL drop all entries with no output handshake that cycle.

Configuration
REQ-028 Macro DFF_PIPE_PARITY_EN defined: each stage SHALL store an even-parity bit of its data, moved with the data; par_err SHALL set when out_valid and stored parity mismatches out_data, and stay set until reset.
REQ-029 Macro undefined: no parity storage; par_err SHALL be tied 0.

Structure
REQ-030 Package dff_pipe_pkg SHALL hold the count-width function and the parity function.
REQ-031 One sub-module dff_pipe_stage (one data/valid/parity slice with load enable) SHALL be instantiated DEPTH times via generate.

Verification
REQ-032 Streaming: DEPTH=4, out_ready=1, inputs 0x01..0x08 back-to-back -> out_data 0x01 first seen 4 cycles after first accept, then 0x02..0x08 consecutively, count steady at 4.
REQ-033 Backpressure: out_ready=0, push 0xA0..0xA5 -> 4 accepted, in_ready=0, count=4; release out_ready -> 0xA0..0xA3 out, in order, then 0xA4 and 0xA5.
REQ-034 Simultaneous: full pipe, in_valid=1 and out_ready=1 for 3 cycles -> count stays 4, no loss.
REQ-035 Flush: count=3, assert flush with in_valid=1 data 0x55 -> next cycle count=0, out_valid=0, 0x55 never emitted.
REQ-036 Reset mid-operation: count=2, reset for 1 cycle -> out_valid=0, out_data=RESET_VAL, count=0, par_err=0.
REQ-037 Parity (macro defined): force one bit of stage DEPTH-1 data while valid -> par_err=1 next edge, held until reset; macro undefined -> par_err stays 0.
